// File: rtl/uart_pkg.sv
// Shared definitions for the UART AXI-Lite scheduler: FSM state encoding,
// arbitration grant type and default UART register offsets.
package uart_pkg;

    typedef enum logic [2:0] {
        POLL_AR,
        POLL_R,
        RX_AR,
        RX_R,
        TX_AW,
        TX_B
    } sched_state_e;

    typedef enum logic {
        GRANT_RX,
        GRANT_TX
    } grant_e;

    localparam logic [3:0] DEF_STAT_ADDR = 4'h8;
    localparam logic [3:0] DEF_RX_ADDR   = 4'h0;
    localparam logic [3:0] DEF_TX_ADDR   = 4'h4;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide circular FIFO with occupancy count; a push at full succeeds when a
// pop happens in the same cycle, a pop at empty never bypasses a push.
module byte_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_axi_sched.sv
// Time-shares one AXI-Lite master between UART status polling, RX reads and
// TX writes. Define UART_SCHED_ERRCNT_EN to enable the AXI error counter.
module uart_axi_sched
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [3:0]  STAT_ADDR  = DEF_STAT_ADDR,
    parameter logic [3:0]  RX_ADDR    = DEF_RX_ADDR,
    parameter logic [3:0]  TX_ADDR    = DEF_TX_ADDR
) (
    input  logic                          clk,
    input  logic                          rstn,
    output logic [3:0]                    m_axi_araddr,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [31:0]                   m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    output logic [3:0]                    m_axi_awaddr,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [31:0]                   m_axi_wdata,
    output logic [3:0]                    m_axi_wstrb,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,
    input  logic                          in_req,
    output logic                          in_ack,
    output logic [7:0]                    in_data,
    input  logic                          out_req,
    output logic                          out_ack,
    input  logic [7:0]                    out_data,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    output logic [7:0]                    err_cnt
);

    sched_state_e state;
    grant_e       last_grant;

    logic       rx_full, rx_empty, tx_full, tx_empty;
    logic [7:0] tx_head;
    logic       r_hs, b_hs;
    logic       rx_push, tx_pop;
    logic       rx_ok, tx_ok;
    logic       unused_ok;

    assign r_hs    = m_axi_rvalid && m_axi_rready;
    assign b_hs    = m_axi_bvalid && m_axi_bready;
    assign rx_push = (state == RX_R) && r_hs && (m_axi_rresp == 2'b00);
    assign tx_pop  = (state == TX_B) && b_hs;
    assign rx_ok   = m_axi_rdata[0] && !rx_full;
    assign tx_ok   = !m_axi_rdata[3] && !tx_empty;

    assign in_ack  = in_req && !rx_empty;
    // out_ack is gated by rstn so it reads 0 while reset is held
    assign out_ack = rstn && out_req && (!tx_full || tx_pop);

    assign unused_ok = ^{m_axi_rdata[31:8], m_axi_bresp};

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (rx_push),
        .push_data (m_axi_rdata[7:0]),
        .pop       (in_ack),
        .head      (in_data),
        .full      (rx_full),
        .empty     (rx_empty),
        .level     (rx_level)
    );

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (out_ack),
        .push_data (out_data),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .level     (tx_level)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= POLL_AR;
            last_grant    <= GRANT_TX;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '1;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
        end else begin
            case (state)
                POLL_AR: begin
                    if (!m_axi_arvalid) begin
                        m_axi_arvalid <= 1'b1;
                        m_axi_araddr  <= STAT_ADDR;
                    end else if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= POLL_R;
                    end
                end
                POLL_R: begin
                    if (r_hs) begin
                        m_axi_rready <= 1'b0;
                        // round-robin: RX wins a tie only if TX was served last
                        if (rx_ok && (!tx_ok || last_grant == GRANT_TX)) begin
                            m_axi_arvalid <= 1'b1;
                            m_axi_araddr  <= RX_ADDR;
                            state         <= RX_AR;
                        end else if (tx_ok) begin
                            m_axi_awvalid <= 1'b1;
                            m_axi_awaddr  <= TX_ADDR;
                            m_axi_wvalid  <= 1'b1;
                            m_axi_wdata   <= {24'd0, tx_head};
                            m_axi_wstrb   <= '1;
                            state         <= TX_AW;
                        end else begin
                            m_axi_arvalid <= 1'b1;
                            m_axi_araddr  <= STAT_ADDR;
                            state         <= POLL_AR;
                        end
                    end
                end
                RX_AR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= RX_R;
                    end
                end
                RX_R: begin
                    if (r_hs) begin
                        m_axi_rready  <= 1'b0;
                        last_grant    <= GRANT_RX;
                        m_axi_arvalid <= 1'b1;
                        m_axi_araddr  <= STAT_ADDR;
                        state         <= POLL_AR;
                    end
                end
                TX_AW: begin
                    if (m_axi_awready) m_axi_awvalid <= 1'b0;
                    if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
                    // move on once neither channel still has a pending handshake
                    if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
                        m_axi_bready <= 1'b1;
                        state        <= TX_B;
                    end
                end
                TX_B: begin
                    if (b_hs) begin
                        m_axi_bready  <= 1'b0;
                        last_grant    <= GRANT_TX;
                        m_axi_arvalid <= 1'b1;
                        m_axi_araddr  <= STAT_ADDR;
                        state         <= POLL_AR;
                    end
                end
                default: state <= POLL_AR;
            endcase
        end
    end

`ifdef UART_SCHED_ERRCNT_EN
    logic err_evt;
    assign err_evt = (r_hs && m_axi_rresp != 2'b00) || (b_hs && m_axi_bresp != 2'b00);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_cnt <= '0;
        end else if (err_evt && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_axi_sched.sv
// Directed bench for uart_axi_sched with a reactive AXI-Lite slave model.
`timescale 1ns/1ps
module tb_uart_axi_sched;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  araddr, awaddr;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] rdata, wdata;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;
    logic        in_req, in_ack, out_req, out_ack;
    logic [7:0]  in_data, out_data, err_cnt;
    logic [2:0]  rx_level, tx_level;

`ifdef UART_SCHED_ERRCNT_EN
    localparam int ERR_EXP = 1;
`else
    localparam int ERR_EXP = 0;
`endif

    // slave configuration, written only by the main sequence
    logic [31:0] stat_val;
    logic [7:0]  rx_byte;
    logic [1:0]  rx_resp;
    int          rx_limit;
    int          aw_delay;
    logic        b_hold;

    // slave/monitor observations, written only by the slave process
    int          rx_reads = 0;
    int          grant_n = 0;
    logic [15:0] grant_seq = '0;
    logic [3:0]  aw_log[$];
    logic [31:0] w_log[$];
    logic [3:0]  wstrb_log[$];
    int          proto_err = 0;
    int          bready_err = 0;
    int          w_first = 0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_axi_sched #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rstn(rstn),
        .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .in_req(in_req), .in_ack(in_ack), .in_data(in_data),
        .out_req(out_req), .out_ack(out_ack), .out_data(out_data),
        .rx_level(rx_level), .tx_level(tx_level), .err_cnt(err_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        out_req = 1'b1;
        out_data = b;
        #1;
        check_eq("push_ack", 32'(out_ack), 32'd1);
        @(posedge clk);
        #1;
        out_req = 1'b0;
    endtask

    task automatic pop_byte(input logic [7:0] exp);
        in_req = 1'b1;
        #1;
        check_eq("pop_ack", 32'(in_ack), 32'd1);
        check_eq("pop_data", 32'(in_data), 32'(exp));
        @(posedge clk);
        #1;
        in_req = 1'b0;
    endtask

    // Slave: acts at falling edges on handshakes completed at the preceding rising edge
    initial begin : slave
        logic p_ar, p_r, p_aw, p_w, p_b, p_arvalid, p_awvalid, p_wvalid;
        logic [3:0]  p_araddr, p_awaddr;
        logic [31:0] p_wdata, rd;
        logic        aw_done, w_done, m_aw, m_w;
        int          aw_wait;
        arready = 1'b1; wready = 1'b1; awready = 1'b0;
        rvalid = 1'b0; rdata = '0; rresp = '0; bvalid = 1'b0; bresp = '0;
        {p_ar, p_r, p_aw, p_w, p_b, p_arvalid, p_awvalid, p_wvalid} = '0;
        p_araddr = '0; p_awaddr = '0; p_wdata = '0;
        {aw_done, w_done, m_aw, m_w} = '0;
        aw_wait = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                rvalid = 1'b0; awready = 1'b0; bvalid = 1'b0;
                {p_ar, p_r, p_aw, p_w, p_b, p_arvalid, p_awvalid, p_wvalid} = '0;
                {aw_done, w_done, m_aw, m_w} = '0;
                aw_wait = 0;
            end else begin
                if (p_arvalid && !p_ar && (!arvalid || araddr != p_araddr)) proto_err++;
                if (p_awvalid && !p_aw && (!awvalid || awaddr != p_awaddr)) proto_err++;
                if (p_wvalid && !p_w && (!wvalid || wdata != p_wdata)) proto_err++;
                if (p_r) rvalid = 1'b0;
                if (p_b) begin
                    bvalid = 1'b0; m_aw = 1'b0; m_w = 1'b0;
                end
                if (p_ar) begin
                    rvalid = 1'b1;
                    if (p_araddr == 4'h8) begin
                        rd = stat_val;
                        if (rx_reads >= rx_limit) rd[0] = 1'b0;
                        rdata = rd;
                        rresp = 2'b00;
                    end else begin
                        rdata = {24'd0, rx_byte};
                        rresp = rx_resp;
                        rx_reads++;
                        grant_seq = {grant_seq[14:0], 1'b0};
                        grant_n++;
                    end
                end
                if (p_aw) begin
                    awready = 1'b0; aw_wait = 0; aw_done = 1'b1; m_aw = 1'b1;
                    aw_log.push_back(p_awaddr);
                    grant_seq = {grant_seq[14:0], 1'b1};
                    grant_n++;
                end
                if (p_w) begin
                    w_done = 1'b1; m_w = 1'b1;
                    w_log.push_back(p_wdata);
                end
                if (aw_done && w_done && !b_hold) begin
                    bvalid = 1'b1; bresp = 2'b00; aw_done = 1'b0; w_done = 1'b0;
                end
                if (awvalid && !awready) begin
                    if (aw_wait >= aw_delay) awready = 1'b1;
                    else aw_wait++;
                end
                if (bready && !(m_aw && m_w)) bready_err++;
                if (awvalid && !wvalid) w_first++;
                if (wvalid) wstrb_log.push_back(wstrb);
                p_ar = arvalid && arready;
                p_r  = rvalid && rready;
                p_aw = awvalid && awready;
                p_w  = wvalid && wready;
                p_b  = bvalid && bready;
                p_arvalid = arvalid; p_awvalid = awvalid; p_wvalid = wvalid;
                p_araddr = araddr; p_awaddr = awaddr; p_wdata = wdata;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: time limit reached at %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin : main
        int r0, g0, w0, a0, wf0, s0;
        rstn = 1'b0; in_req = 1'b0; out_req = 1'b1; out_data = 8'h00;
        stat_val = '0; rx_byte = '0; rx_resp = '0; rx_limit = 0; aw_delay = 0; b_hold = 1'b0;

        repeat (3) tick();
        check_eq("rst_valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
        check_eq("rst_addr", 32'({araddr, awaddr}), 32'd0);
        check_eq("rst_wdata", wdata, 32'd0);
        check_eq("rst_wstrb", 32'(wstrb), 32'hF);
        check_eq("rst_levels", 32'({rx_level, tx_level}), 32'd0);
        check_eq("rst_errcnt", 32'(err_cnt), 32'd0);
        check_eq("rst_acks", 32'({in_ack, out_ack}), 32'd0);
        out_req = 1'b0;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check_eq("release_ar", 32'({arvalid, araddr}), 32'h18);

        // single RX byte with in_req already waiting
        tick();
        r0 = rx_reads;
        rx_byte = 8'h41; rx_limit = rx_reads + 1; stat_val = 32'h1; in_req = 1'b1;
        for (int i = 0; i < 100 && !in_ack; i++) tick();
        check_eq("rx_ack", 32'(in_ack), 32'd1);
        check_eq("rx_data", 32'(in_data), 32'h41);
        check_eq("rx_level1", 32'(rx_level), 32'd1);
        @(posedge clk);
        #1;
        check_eq("rx_level0", 32'(rx_level), 32'd0);
        check_eq("rx_ack_drop", 32'(in_ack), 32'd0);
        in_req = 1'b0;
        repeat (20) tick();
        check_eq("rx_one_read", 32'(rx_reads - r0), 32'd1);

        // single TX byte
        stat_val = 32'h0;
        a0 = aw_log.size(); w0 = w_log.size(); s0 = wstrb_log.size();
        push_byte(8'h5A);
        check_eq("tx_level1", 32'(tx_level), 32'd1);
        for (int i = 0; i < 100 && tx_level != 0; i++) tick();
        check_eq("tx_level0", 32'(tx_level), 32'd0);
        check_eq("tx_aw_cnt", 32'(aw_log.size() - a0), 32'd1);
        check_eq("tx_awaddr", 32'(aw_log[a0]), 32'h4);
        check_eq("tx_wdata", w_log[w0], 32'h5A);
        check_eq("tx_wstrb", 32'(wstrb_log[s0]), 32'hF);
        check_eq("tx_bready_order", 32'(bready_err), 32'd0);

        // round-robin with RX and TX both ready
        stat_val = 32'h8;
        repeat (4) tick();
        w0 = w_log.size();
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        check_eq("rr_tx_level", 32'(tx_level), 32'd3);
        g0 = grant_n;
        rx_byte = 8'h5C; rx_limit = rx_reads + 2; stat_val = 32'h1;
        for (int i = 0; i < 300 && !(tx_level == 0 && grant_n - g0 >= 5); i++) tick();
        check_eq("rr_count", 32'(grant_n - g0), 32'd5);
        check_eq("rr_order", 32'(grant_seq[4:0]), 32'h0B);
        check_eq("rr_w0", w_log[w0], 32'h11);
        check_eq("rr_w1", w_log[w0+1], 32'h22);
        check_eq("rr_w2", w_log[w0+2], 32'h33);
        check_eq("rr_rx_level", 32'(rx_level), 32'd2);
        pop_byte(8'h5C);
        pop_byte(8'h5C);

        // RX FIFO full blocks RX reads until a slot frees
        rx_byte = 8'h60; rx_limit = rx_reads + 4; stat_val = 32'h1;
        for (int i = 0; i < 200 && rx_level != 4; i++) tick();
        check_eq("full_level", 32'(rx_level), 32'd4);
        rx_limit = rx_reads + 1000;
        r0 = rx_reads;
        repeat (30) tick();
        check_eq("full_no_read", 32'(rx_reads - r0), 32'd0);
        pop_byte(8'h60);
        for (int i = 0; i < 100 && rx_reads == r0; i++) tick();
        repeat (10) tick();
        check_eq("full_refill_reads", 32'(rx_reads - r0), 32'd1);
        check_eq("full_refill_level", 32'(rx_level), 32'd4);
        rx_limit = 0;
        repeat (4) tick();
        for (int k = 0; k < 4; k++) pop_byte(8'h60);
        check_eq("full_drained", 32'(rx_level), 32'd0);

        // AW ready delayed, W ready immediate
        stat_val = 32'h0; aw_delay = 3;
        a0 = aw_log.size(); w0 = w_log.size(); wf0 = w_first;
        push_byte(8'h77);
        for (int i = 0; i < 100 && tx_level != 0; i++) tick();
        check_eq("awdly_level", 32'(tx_level), 32'd0);
        check_eq("awdly_w_first", 32'(w_first - wf0), 32'd3);
        check_eq("awdly_awaddr", 32'(aw_log[a0]), 32'h4);
        check_eq("awdly_wdata", w_log[w0], 32'h77);
        check_eq("awdly_bready_order", 32'(bready_err), 32'd0);
        aw_delay = 0;

        // errored RX read is discarded
        r0 = rx_reads;
        rx_resp = 2'b10; rx_byte = 8'h99; rx_limit = rx_reads + 1; stat_val = 32'h1;
        for (int i = 0; i < 100 && rx_reads == r0; i++) tick();
        repeat (5) tick();
        check_eq("err_read_done", 32'(rx_reads - r0), 32'd1);
        check_eq("err_rx_level", 32'(rx_level), 32'd0);
        check_eq("err_cnt", 32'(err_cnt), 32'(ERR_EXP));
        rx_resp = 2'b00;

        // reset while waiting for the write response
        stat_val = 32'h0; b_hold = 1'b1;
        push_byte(8'hAB);
        for (int i = 0; i < 100 && !bready; i++) tick();
        check_eq("txb_bready", 32'(bready), 32'd1);
        rstn = 1'b0;
        #1;
        check_eq("mid_rst_valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
        check_eq("mid_rst_addr", 32'({araddr, awaddr}), 32'd0);
        check_eq("mid_rst_wdata", wdata, 32'd0);
        check_eq("mid_rst_wstrb", 32'(wstrb), 32'hF);
        check_eq("mid_rst_levels", 32'({rx_level, tx_level}), 32'd0);
        check_eq("mid_rst_misc", 32'({err_cnt, in_ack, out_ack}), 32'd0);
        b_hold = 1'b0;
        tick();
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rerelease_ar", 32'({arvalid, araddr}), 32'h18);
        check_eq("rerelease_aw", 32'({awvalid, wvalid, bready}), 32'd0);
        repeat (5) tick();
        check_eq("protocol_stable", 32'(proto_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
